ram_loader: RTL

Program loader that sits directly upstream of the single-port program RAM. It accepts a byte stream over a valid/ready handshake, writes it sequentially into RAM from address 0, then reads the image back through the RAM's one-cycle read port to verify a modular checksum. Outside a load it passes the CPU's memory bus straight through to the RAM. During a load it holds the CPU off the bus.

---
 rtl/pdua_mem_pkg.sv | 15 +
 rtl/ram_bus_mux.sv | 22 ++
 rtl/ram_loader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pdua_mem_pkg.sv
// Shared definitions for the program-memory loader: state encoding and default bus widths.
package pdua_mem_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VERIFY,
    DRAIN,
    REPORT
  } loader_state_t;

endpackage

// File: rtl/ram_bus_mux.sv
// Selects which master drives the program RAM: the CPU, or the loader while it holds the CPU off.
module ram_bus_mux #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  cpu_hold,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_w_data,
  input  logic                  cpu_wr_rdn,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_w_data,
  input  logic                  ldr_wr_rdn,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  output logic                  ram_wr_rdn
);

  assign ram_addr   = cpu_hold ? ldr_addr   : cpu_addr;
  assign ram_w_data = cpu_hold ? ldr_w_data : cpu_w_data;
  assign ram_wr_rdn = cpu_hold ? ldr_wr_rdn : cpu_wr_rdn;

endmodule

// File: rtl/ram_loader.sv
// Streams a program image into RAM from address 0, reads it back to verify a modular
// checksum, and passes the CPU bus straight through to the RAM whenever no load is running.
module ram_loader
  import pdua_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_w_data,
  input  logic                  cpu_wr_rdn,
  output logic                  cpu_hold,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  output logic                  ram_wr_rdn,
  input  logic [DATA_WIDTH-1:0] ram_r_data,
  output logic                  done,
  output logic                  pass,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = '1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);

  loader_state_t state, state_next;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [DATA_WIDTH-1:0] wsum;
  logic [DATA_WIDTH-1:0] rsum;
  logic [DATA_WIDTH-1:0] rsum_acc;
  logic                  rd_valid;
  logic                  handshake;
  logic [ADDR_WIDTH-1:0] ldr_addr;
  logic [DATA_WIDTH-1:0] ldr_w_data;
  logic                  ldr_wr_rdn;

  assign handshake = in_valid && in_ready;
  // rd_valid marks the cycle in which ram_r_data answers the previous cycle's address
  assign rsum_acc  = rd_valid ? rsum + ram_r_data : rsum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    ldr_addr   = '0;
    ldr_w_data = '0;
    ldr_wr_rdn = 1'b0;
    case (state)
      IDLE: begin
        cpu_hold = 1'b0;
        if (start) state_next = LOAD;
      end
      LOAD: begin
        in_ready   = 1'b1;
        ldr_addr   = wr_ptr;
        ldr_w_data = in_data;
        ldr_wr_rdn = handshake;
        if (handshake && (in_last || wr_ptr == TOP_ADDR)) state_next = VERIFY;
      end
      VERIFY: begin
        ldr_addr = rd_ptr[ADDR_WIDTH-1:0];
        if (rd_ptr == count - CNT_ONE) state_next = DRAIN;
      end
      DRAIN:   state_next = REPORT;
      REPORT: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: pointers and sums; pass is settled as REPORT is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wsum     <= '0;
      rsum     <= '0;
      rd_valid <= 1'b0;
      pass     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rd_valid <= (state == VERIFY);
      case (state)
        IDLE: begin
          if (start) begin
            wr_ptr   <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wsum     <= '0;
            rsum     <= '0;
            pass     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        LOAD: begin
          if (handshake) begin
            wsum  <= wsum + in_data;
            count <= count + CNT_ONE;
            if (!in_last) begin
              if (wr_ptr == TOP_ADDR) overflow <= 1'b1;
              else                    wr_ptr   <= wr_ptr + ADDR_WIDTH'(1);
            end
          end
        end
        VERIFY: begin
          rd_ptr <= rd_ptr + CNT_ONE;
          rsum   <= rsum_acc;
        end
        DRAIN: begin
          rsum <= rsum_acc;
          pass <= (rsum_acc == wsum);
        end
        default: ;
      endcase
    end
  end

  ram_bus_mux #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bus_mux (
    .cpu_hold  (cpu_hold),
    .cpu_addr  (cpu_addr),
    .cpu_w_data(cpu_w_data),
    .cpu_wr_rdn(cpu_wr_rdn),
    .ldr_addr  (ldr_addr),
    .ldr_w_data(ldr_w_data),
    .ldr_wr_rdn(ldr_wr_rdn),
    .ram_addr  (ram_addr),
    .ram_w_data(ram_w_data),
    .ram_wr_rdn(ram_wr_rdn)
  );

endmodule
